// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between the branch predictor/execute side (master) and the
// branch resolve unit (slave): predictions in, outcomes in, training updates out.
interface branch_resolve_unit_if #(
  parameter int IDX_W = 1
);
  logic             pred_valid;
  logic             pred_ready;
  logic [IDX_W-1:0] pred_idx;
  logic [1:0]       pred_cnt;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_mispredict;
  logic             flush;

  modport master (
    output pred_valid, pred_idx, pred_cnt, res_valid, res_taken,
    input  pred_ready, res_ready, upd_valid, upd_idx, upd_taken, upd_mispredict, flush
  );

  modport slave (
    input  pred_valid, pred_idx, pred_cnt, res_valid, res_taken,
    output pred_ready, res_ready, upd_valid, upd_idx, upd_taken, upd_mispredict, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order prediction FIFO checked against execute outcomes,
// emitting training updates and a flush on mispredict. BRU_CONF_STATS_EN adds weak/strong counters.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 1,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_resolve_unit_if.slave     bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mismatch,
  output logic [CNT_W-1:0]         resolved
`ifdef BRU_CONF_STATS_EN
  ,
  output logic [CNT_W-1:0]         weak_mispredict,
  output logic [CNT_W-1:0]         strong_mispredict
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_r, state_nxt_s;
  logic [IDX_W+1:0]    mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [AW:0]         occ_r;
  logic                upd_valid_r, upd_taken_r, upd_mis_r, flush_r;
  logic [IDX_W-1:0]    upd_idx_r;
  logic [CNT_W-1:0]    mismatch_r, resolved_r;

  logic                full_s, empty_s, pred_ready_s, res_ready_s, push_s, pop_s, mis_s;
  logic [IDX_W-1:0]    head_idx_s;
  logic [1:0]          head_cnt_s;

  assign full_s       = (occ_r == FULL_OCC);
  assign empty_s      = (occ_r == '0);
  assign pred_ready_s = (state_r == ST_RUN) && !full_s;
  assign res_ready_s  = (state_r == ST_RUN) && !empty_s;
  assign push_s       = bus.pred_valid && pred_ready_s;
  assign pop_s        = bus.res_valid && res_ready_s;
  assign head_idx_s   = mem_r[rd_ptr_r][IDX_W+1:2];
  assign head_cnt_s   = mem_r[rd_ptr_r][1:0];
  assign mis_s        = pop_s && (bus.res_taken != head_cnt_s[1]);

  assign bus.pred_ready     = pred_ready_s;
  assign bus.res_ready      = res_ready_s;
  assign bus.upd_valid      = upd_valid_r;
  assign bus.upd_idx        = upd_idx_r;
  assign bus.upd_taken      = upd_taken_r;
  assign bus.upd_mispredict = upd_mis_r;
  assign bus.flush          = flush_r;
  assign occupancy          = occ_r;
  assign mismatch           = mismatch_r;
  assign resolved           = resolved_r;

  // FSM next state: a mispredicting pop enters the one-cycle flush window
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mis_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prediction FIFO; a mispredict discards everything, including a same-cycle push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (mis_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.pred_idx, bus.pred_cnt};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (AW+1)'(1);
        2'b01:   occ_r <= occ_r - (AW+1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Training update and flush pulses, zeroed in every cycle not following a pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_r <= 1'b0;
      upd_idx_r   <= '0;
      upd_taken_r <= 1'b0;
      upd_mis_r   <= 1'b0;
      flush_r     <= 1'b0;
    end else begin
      upd_valid_r <= pop_s;
      upd_idx_r   <= pop_s ? head_idx_s : '0;
      upd_taken_r <= pop_s && bus.res_taken;
      upd_mis_r   <= mis_s;
      flush_r     <= mis_s;
    end
  end

  // Saturating resolved/mismatch statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_r <= '0;
      resolved_r <= '0;
    end else begin
      if (pop_s) begin
        resolved_r <= sat_inc(resolved_r);
      end
      if (mis_s) begin
        mismatch_r <= sat_inc(mismatch_r);
      end
    end
  end

`ifdef BRU_CONF_STATS_EN
  logic [CNT_W-1:0] weak_r, strong_r;

  assign weak_mispredict   = weak_r;
  assign strong_mispredict = strong_r;

  // Mispredict split by counter confidence: 01/10 weak, 00/11 strong
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weak_r   <= '0;
      strong_r <= '0;
    end else if (mis_s) begin
      if (^head_cnt_s) begin
        weak_r <= sat_inc(weak_r);
      end else begin
        strong_r <= sat_inc(strong_r);
      end
    end
  end
`else
  logic unused_cnt_lsb_s;
  assign unused_cnt_lsb_s = head_cnt_s[0];
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 8;
  localparam int IDX_W = 1;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.IDX_W(IDX_W)) bus();
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       mismatch, resolved;
`ifdef BRU_CONF_STATS_EN
  logic [CNT_W-1:0]       weak_mispredict, strong_mispredict;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .occupancy(occupancy),
    .mismatch(mismatch),
    .resolved(resolved)
`ifdef BRU_CONF_STATS_EN
    ,
    .weak_mispredict(weak_mispredict),
    .strong_mispredict(strong_mispredict)
`endif
  );

  typedef struct packed {logic [IDX_W-1:0] idx; logic [1:0] cnt;} pred_t;
  typedef struct packed {logic [IDX_W-1:0] idx; logic taken; logic mis;} upd_t;

  pred_t mq[$];
  upd_t  sb[$];
  int    total = 0;
  int    bad = 0;
  bit    m_flush = 1'b0;
  int unsigned m_mismatch = 0, m_resolved = 0, m_weak = 0, m_strong = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit pv, input logic [IDX_W-1:0] idx, input logic [1:0] cnt,
                       input bit rv, input bit tk);
    bus.pred_valid = pv;
    bus.pred_idx   = idx;
    bus.pred_cnt   = cnt;
    bus.res_valid  = rv;
    bus.res_taken  = tk;
  endtask

  // One clock of stimulus: checks visible state against the model, then advances the model
  task automatic step(input bit pv, input logic [IDX_W-1:0] idx, input logic [1:0] cnt,
                      input bit rv, input bit tk);
    bit exp_pr, exp_rr, push, pop, mis;
    pred_t h;
    @(negedge clk);
    drive(pv, idx, cnt, rv, tk);
    #1;
    exp_pr = !m_flush && (mq.size() < DEPTH);
    exp_rr = !m_flush && (mq.size() != 0);
    chk("pred_ready", bus.pred_ready, exp_pr);
    chk("res_ready", bus.res_ready, exp_rr);
    chk("occupancy", occupancy, mq.size());
    chk("mismatch", mismatch, m_mismatch);
    chk("resolved", resolved, m_resolved);
`ifdef BRU_CONF_STATS_EN
    chk("weak_mispredict", weak_mispredict, m_weak);
    chk("strong_mispredict", strong_mispredict, m_strong);
`endif
    push = pv && exp_pr;
    pop  = rv && exp_rr;
    mis  = 1'b0;
    if (pop) begin
      h   = mq.pop_front();
      mis = (tk != h.cnt[1]);
      sb.push_back('{idx: h.idx, taken: tk, mis: mis});
      m_resolved++;
      if (mis) begin
        m_mismatch++;
        if (h.cnt == 2'b01 || h.cnt == 2'b10) m_weak++;
        else m_strong++;
        mq.delete();
      end
    end
    if (push && !mis) mq.push_back('{idx: idx, cnt: cnt});
    m_flush = mis;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("rst occupancy", occupancy, 0);
    chk("rst mismatch", mismatch, 0);
    chk("rst resolved", resolved, 0);
    chk("rst upd_valid", bus.upd_valid, 0);
    chk("rst flush", bus.flush, 0);
    chk("rst res_ready", bus.res_ready, 0);
`ifdef BRU_CONF_STATS_EN
    chk("rst weak", weak_mispredict, 0);
    chk("rst strong", strong_mispredict, 0);
`endif
    mq.delete();
    sb.delete();
    m_flush = 1'b0;
    m_mismatch = 0; m_resolved = 0; m_weak = 0; m_strong = 0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every update pulse must match the oldest expected entry; no pulse means nothing pending
  always begin
    upd_t e;
    @(posedge clk);
    #2;
    if (bus.upd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious upd_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("upd_idx", bus.upd_idx, e.idx);
        chk("upd_taken", bus.upd_taken, e.taken);
        chk("upd_mispredict", bus.upd_mispredict, e.mis);
        chk("flush", bus.flush, e.mis);
      end
    end else begin
      chk("idle upd/flush", {bus.upd_mispredict, bus.flush, bus.upd_taken, bus.upd_idx}, 0);
      if (sb.size() != 0) begin
        chk("missing upd_valid", 0, 1);
        e = sb.pop_front();
      end
    end
  end

  initial begin
    bit tk;
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0);
    do_reset(3);

    // single correct resolution
    step(1, 0, 2'b11, 0, 0);
    step(0, 0, 2'b00, 1, 1);
    repeat (2) step(0, 0, 2'b00, 0, 0);

    // fill past capacity; extra offers must be held off
    for (int i = 0; i < 10; i++) step(1, IDX_W'(i), 2'b11, 0, 0);
    // simultaneous push/pop at full: no pass-through
    step(1, 1, 2'b11, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 2'b00, 1, 1);

    // three queued, head mispredicts
    step(1, 0, 2'b11, 0, 0);
    step(1, 1, 2'b00, 0, 0);
    step(1, 0, 2'b11, 0, 0);
    step(1, 1, 2'b10, 1, 0);
    repeat (3) step(1, 0, 2'b01, 0, 0);

    // occupancy 4, push+pop same cycle with correct prediction
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, IDX_W'(i), 2'b10, 0, 0);
    step(1, 1, 2'b11, 1, 1);
    step(0, 0, 2'b00, 0, 0);

    // weak then strong mispredict, then reset with entries queued
    do_reset(1);
    step(1, 1, 2'b01, 0, 0);
    step(0, 0, 2'b00, 1, 1);
    step(0, 0, 2'b00, 0, 0);
    step(1, 0, 2'b11, 0, 0);
    step(0, 0, 2'b00, 1, 0);
    step(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, IDX_W'(i), 2'b11, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    do_reset(2);

    // randomized traffic, mostly-correct outcomes so the queue gets deep
    for (int n = 0; n < 3000; n++) begin
      if (mq.size() != 0 && ($urandom_range(0, 7) != 0)) tk = mq[0].cnt[1];
      else tk = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 3) != 0), IDX_W'($urandom), 2'($urandom),
           (n % 200 < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0), tk);
    end
    repeat (3) step(0, 0, 2'b00, 0, 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
